// File: rtl/io_out_buffer_if.sv
// Handshake bundle between the CPU output port, the buffer and the peripheral.
// IO_OUT_PARITY_EN adds the per_parity signal to the bundle.
interface io_out_buffer_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;
  logic             per_valid;
  logic [WIDTH-1:0] per_data;
  logic             per_ready;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
`ifdef IO_OUT_PARITY_EN
  logic             per_parity;

  modport slave (
    input  out_req, out_data, per_ready,
    output out_ack, per_valid, per_data, count, full, empty, per_parity
  );
  modport master (
    output out_req, out_data, per_ready,
    input  out_ack, per_valid, per_data, count, full, empty, per_parity
  );
`else
  modport slave (
    input  out_req, out_data, per_ready,
    output out_ack, per_valid, per_data, count, full, empty
  );
  modport master (
    output out_req, out_data, per_ready,
    input  out_ack, per_valid, per_data, count, full, empty
  );
`endif
endinterface

// File: rtl/io_out_buffer.sv
// CPU-to-peripheral output FIFO with req/ack accept FSM.
// Optional IO_OUT_PARITY_EN stores even parity with each word and exposes per_parity.
module io_out_buffer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst_b,
  io_out_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
`ifdef IO_OUT_PARITY_EN
  localparam int EW = WIDTH + 1;
`else
  localparam int EW = WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

  state_t        state;
  logic          ack_r;
  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_next;
  logic          full_r, empty_r;
  logic          push, pop;
  logic [EW-1:0] wr_entry, head;

  // full is the registered flag, so a same-cycle pop never admits a push
  assign push = (state == IDLE) && bus.out_req && !full_r;
  assign pop  = !empty_r && bus.per_ready;

`ifdef IO_OUT_PARITY_EN
  assign wr_entry = {^bus.out_data, bus.out_data};
`else
  assign wr_entry = bus.out_data;
`endif

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state <= IDLE;
      ack_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ack_r <= push;
          if (push) state <= ACK;
        end
        ACK: begin
          ack_r <= 1'b0;
          state <= bus.out_req ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          ack_r <= 1'b0;
          if (!bus.out_req) state <= IDLE;
        end
        default: begin
          ack_r <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt     <= cnt_next;
      full_r  <= (cnt_next == FULL_COUNT);
      empty_r <= (cnt_next == '0);
    end
  end

  // storage is not reset; empty masks stale contents
  always_ff @(posedge clk) begin
    if (rst_b && push) mem[wr_ptr] <= wr_entry;
  end

  assign head          = mem[rd_ptr];
  assign bus.out_ack   = ack_r;
  assign bus.per_valid = !empty_r;
  assign bus.per_data  = head[WIDTH-1:0];
  assign bus.count     = cnt;
  assign bus.full      = full_r;
  assign bus.empty     = empty_r;
`ifdef IO_OUT_PARITY_EN
  assign bus.per_parity = head[WIDTH] & !empty_r;
`endif
endmodule

// File: tb/tb_io_out_buffer.sv
// Directed bench for io_out_buffer: handshake, fill/stall, wrap, stream, reset, parity.
// Define IO_OUT_PARITY_EN to also exercise the parity output.
module tb_io_out_buffer;
  logic clk;
  logic rst_b;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   acks;

  io_out_buffer_if #(.WIDTH(16), .DEPTH(8)) bus ();

  io_out_buffer #(.WIDTH(16), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
  endtask

  task automatic push_word(input logic [15:0] d);
    int waited = 0;
    bus.out_req  = 1'b1;
    bus.out_data = d;
    tick();
    while (!bus.out_ack && waited < 20) begin
      tick();
      waited++;
    end
    check("push_ack", 32'(bus.out_ack), 32'd1);
    bus.out_req = 1'b0;
    tick();
  endtask

  initial begin
    bus.out_req   = 1'b0;
    bus.out_data  = '0;
    bus.per_ready = 1'b0;
    rst_b         = 1'b0;
    do_reset();

    check("rst_ack",   32'(bus.out_ack),   32'd0);
    check("rst_valid", 32'(bus.per_valid), 32'd0);
    check("rst_empty", 32'(bus.empty),     32'd1);
    check("rst_full",  32'(bus.full),      32'd0);
    check("rst_count", 32'(bus.count),     32'd0);
`ifdef IO_OUT_PARITY_EN
    check("rst_parity", 32'(bus.per_parity), 32'd0);
`endif

    // first request: ack and data one cycle after the sampling edge
    bus.out_req  = 1'b1;
    bus.out_data = 16'h1234;
    tick();
    check("first_ack",   32'(bus.out_ack),   32'd1);
    check("first_valid", 32'(bus.per_valid), 32'd1);
    check("first_data",  32'(bus.per_data),  32'h1234);
    check("first_count", 32'(bus.count),     32'd1);

    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.out_ack) acks++;
    end
    check("held_extra_acks", 32'(acks),      32'd0);
    check("held_count",      32'(bus.count), 32'd1);

    bus.out_req = 1'b0;
    tick();
    bus.out_req  = 1'b1;
    bus.out_data = 16'h0002;
    tick();
    check("second_ack",   32'(bus.out_ack),  32'd1);
    check("second_count", 32'(bus.count),    32'd2);
    check("second_head",  32'(bus.per_data), 32'h1234);
    bus.out_req = 1'b0;
    tick();

    // fill, stall while full, then wrap
    do_reset();
    for (int i = 0; i < 8; i++) push_word(16'(i));
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_count", 32'(bus.count), 32'd8);

    bus.out_req  = 1'b1;
    bus.out_data = 16'h0008;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.out_ack) acks++;
    end
    check("stall_no_ack", 32'(acks),      32'd0);
    check("stall_count",  32'(bus.count), 32'd8);

    bus.per_ready = 1'b1;
    tick();
    bus.per_ready = 1'b0;
    check("pop_while_full_ack",   32'(bus.out_ack),  32'd0);
    check("pop_while_full_count", 32'(bus.count),    32'd7);
    check("pop_while_full_flag",  32'(bus.full),     32'd0);
    check("pop_while_full_head",  32'(bus.per_data), 32'd1);
    tick();
    check("late_push_ack",   32'(bus.out_ack), 32'd1);
    check("late_push_count", 32'(bus.count),   32'd8);
    check("late_push_full",  32'(bus.full),    32'd1);
    bus.out_req = 1'b0;
    tick();

    bus.per_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.per_data), 32'(i));
      tick();
    end
    bus.per_ready = 1'b0;
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);

    // simultaneous push and pop keep occupancy constant
    push_word(16'd100);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stream_head_%0d", k), 32'(bus.per_data), 32'(100 + k));
      bus.out_req   = 1'b1;
      bus.out_data  = 16'(101 + k);
      bus.per_ready = 1'b1;
      tick();
      check($sformatf("stream_ack_%0d", k),   32'(bus.out_ack),  32'd1);
      check($sformatf("stream_count_%0d", k), 32'(bus.count),    32'd1);
      check($sformatf("stream_new_%0d", k),   32'(bus.per_data), 32'(101 + k));
      bus.out_req   = 1'b0;
      bus.per_ready = 1'b0;
      tick();
    end

    // reset while in ACK discards the pending handshake
    do_reset();
    push_word(16'h0a);
    push_word(16'h0b);
    push_word(16'h0c);
    check("pre_rst_count", 32'(bus.count), 32'd3);
    bus.out_req  = 1'b1;
    bus.out_data = 16'h0055;
    tick();
    check("in_ack", 32'(bus.out_ack), 32'd1);
    rst_b = 1'b0;
    tick();
    check("mid_rst_count", 32'(bus.count),     32'd0);
    check("mid_rst_empty", 32'(bus.empty),     32'd1);
    check("mid_rst_ack",   32'(bus.out_ack),   32'd0);
    check("mid_rst_valid", 32'(bus.per_valid), 32'd0);
    rst_b = 1'b1;
    tick();
    check("reaccept_ack",   32'(bus.out_ack),  32'd1);
    check("reaccept_count", 32'(bus.count),    32'd1);
    check("reaccept_data",  32'(bus.per_data), 32'h0055);
    bus.out_req = 1'b0;
    tick();

`ifdef IO_OUT_PARITY_EN
    do_reset();
    push_word(16'h0007);
    check("parity_odd", 32'(bus.per_parity), 32'd1);
    bus.per_ready = 1'b1;
    tick();
    bus.per_ready = 1'b0;
    push_word(16'h0003);
    check("parity_even", 32'(bus.per_parity), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/io_out_buffer.md
IO_OUT_BUFFER -- requirements
Module: io_out_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; a power of two, at least 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_b  input  1  reset; synchronous, active-low.
REQ-005 SHALL have port out_req  input  1  CPU output request, level, held until out_ack is seen.
REQ-006 SHALL have port out_data  input  WIDTH  CPU output word, valid while out_req=1.
REQ-007 SHALL have port out_ack  output  1  one-cycle pulse: word accepted.
REQ-008 SHALL have port per_valid  output  1  head word available to peripheral.
REQ-009 SHALL have port per_data  output  WIDTH  head word.
REQ-010 SHALL have port per_ready  input  1  peripheral consumes head when per_valid=1 and per_ready=1.
REQ-011 SHALL have port count  output  clog2(DEPTH)+1  current occupancy.
REQ-012 SHALL have port full  output  1  count==DEPTH.
REQ-013 SHALL have port empty  output  1  count==0.

Function
REQ-014 SHALL implement a circular FIFO with registered read pointer, write pointer and count; pointers wrap from DEPTH-1 to 0.
REQ-015 SHALL run an accept FSM with states IDLE, ACK and WAIT_LOW.
REQ-016 IDLE: if out_req=1 and full=0 at the edge, SHALL write out_data and go to ACK; otherwise stay in IDLE.
REQ-017 ACK: SHALL drive out_ack=1 for exactly this cycle, then go to WAIT_LOW, or to IDLE if out_req=0.
REQ-018 WAIT_LOW: SHALL remain until out_req=0, then go to IDLE; no write occurs while in ACK or WAIT_LOW.
REQ-019 A held out_req SHALL produce exactly one write and one out_ack.
REQ-020 Latency: out_req sampled in cycle N with full=0 -> out_ack=1 in N+1; word is visible on per_data in N+1 if the FIFO was empty.
REQ-021 When full=1, out_req SHALL be stalled with no ack and no write until a pop frees an entry.
REQ-022 per_valid SHALL equal ~empty; per_data SHALL be the entry at the read pointer; per_data is don't-care when empty.
REQ-023 A pop SHALL occur when per_valid and per_ready; per_ready is ignored when empty.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-025 Full is evaluated before the edge: a pop in the same cycle does not let a push proceed when full=1; the push is taken next cycle.
REQ-026 count, full and empty SHALL be registered-consistent: they update on the same edge as the pointers.

Reset
REQ-027 rst_b=0 at an edge SHALL clear pointers and count, force the FSM to IDLE, and set out_ack=0, per_valid=0, empty=1, full=0; storage contents need not clear.
REQ-028 Reset asserted mid-handshake (ACK or WAIT_LOW) SHALL discard the pending ack; after release, a still-high out_req is treated as a new request.

Configuration
REQ-029 Macro IO_OUT_PARITY_EN defined: SHALL add output per_parity (1 bit), the even parity (XOR) of the word, computed at write and stored alongside it in a WIDTH+1-bit entry; per_parity=0 after reset.
REQ-030 Macro IO_OUT_PARITY_EN undefined: per_parity port and parity storage SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Reset, then out_req=1 with out_data=16'h1234 and per_ready=0 -> out_ack pulse in cycle 2 only; per_valid=1, per_data=16'h1234, count=1.
REQ-032 Hold out_req=1 for 10 cycles -> exactly one out_ack; count stays 1; deassert and reassert with 16'h0002 -> second ack; count=2.
REQ-033 Fill 8 words 0..7 with per_ready=0 -> full=1; a 9th request sees no ack until one per_ready cycle; data then drains in order 1..7,8 with wrap-around.
REQ-034 Steady stream with per_ready=1 and the FIFO non-empty -> simultaneous push/pop cycles keep count constant; output order matches input order.
REQ-035 rst_b=0 during ACK with 3 words stored -> count=0, empty=1, out_ack=0 next cycle; held out_req is re-accepted after release.
REQ-036 With IO_OUT_PARITY_EN defined, write 16'h0007 -> per_parity=1; write 16'h0003 -> per_parity=0.
